// File: rtl/mm_master.sv
// Avalon-MM initiator: turns a valid/ready command stream into single read/write transfers with one response per command.
// Optional stall timeout enabled by defining MM_MASTER_TIMEOUT_EN (limit set by TIMEOUT).
`timescale 1ns/1ps
module mm_master #(
  parameter int AW      = 8,
  parameter int DW      = 16,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_address,
  input  logic [DW-1:0] cmd_writedata,
  output logic          rsp_valid,
  output logic          rsp_write,
  output logic [DW-1:0] rsp_readdata,
  output logic          rsp_error,
  output logic [AW-1:0] address,
  output logic          read,
  output logic          write,
  output logic [DW-1:0] writedata,
  input  logic [DW-1:0] readdata,
  input  logic          waitrequest
);

  typedef enum logic [0:0] {IDLE, BUSY} state_t;

  state_t        state_reg, state_next;
  logic [AW-1:0] address_next;
  logic [DW-1:0] writedata_next;
  logic          read_next, write_next;
  logic          rsp_valid_next, rsp_write_next;
  logic [DW-1:0] rsp_readdata_next;
  logic          done, abort, accept;

  assign done = (state_reg == BUSY) && !waitrequest;

`ifdef MM_MASTER_TIMEOUT_EN
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [CW-1:0] stall_cnt_reg, stall_cnt_next;
  logic          rsp_error_reg;

  // Abort on the stall cycle that would bring the count up to TIMEOUT.
  assign abort     = (state_reg == BUSY) && waitrequest && (stall_cnt_reg == CW'(TIMEOUT - 1));
  assign rsp_error = rsp_error_reg;

  always_comb begin
    stall_cnt_next = stall_cnt_reg;
    if (accept)
      stall_cnt_next = '0;
    else if ((state_reg == BUSY) && waitrequest)
      stall_cnt_next = stall_cnt_reg + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_reg <= '0;
      rsp_error_reg <= 1'b0;
    end else begin
      stall_cnt_reg <= stall_cnt_next;
      rsp_error_reg <= abort;
    end
  end
`else
  assign abort     = 1'b0;
  assign rsp_error = 1'b0;
`endif

  // Ready during a completion lets the next command load in the same edge (back-to-back).
  assign cmd_ready = (state_reg == IDLE) || done;
  assign accept    = cmd_valid && cmd_ready;

  always_comb begin
    state_next     = state_reg;
    address_next   = address;
    writedata_next = writedata;
    read_next      = read;
    write_next     = write;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          address_next   = cmd_address;
          writedata_next = cmd_writedata;
          read_next      = !cmd_write;
          write_next     = cmd_write;
          state_next     = BUSY;
        end
      end
      BUSY: begin
        if (done) begin
          if (cmd_valid) begin
            address_next   = cmd_address;
            writedata_next = cmd_writedata;
            read_next      = !cmd_write;
            write_next     = cmd_write;
          end else begin
            read_next  = 1'b0;
            write_next = 1'b0;
            state_next = IDLE;
          end
        end else if (abort) begin
          read_next  = 1'b0;
          write_next = 1'b0;
          state_next = IDLE;
        end
      end
      default: begin
        read_next  = 1'b0;
        write_next = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    rsp_valid_next    = done || abort;
    rsp_write_next    = (done || abort) ? write : rsp_write;
    rsp_readdata_next = (done && read) ? readdata : rsp_readdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      address      <= '0;
      writedata    <= '0;
      read         <= 1'b0;
      write        <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_write    <= 1'b0;
      rsp_readdata <= '0;
    end else begin
      state_reg    <= state_next;
      address      <= address_next;
      writedata    <= writedata_next;
      read         <= read_next;
      write        <= write_next;
      rsp_valid    <= rsp_valid_next;
      rsp_write    <= rsp_write_next;
      rsp_readdata <= rsp_readdata_next;
    end
  end

endmodule

// File: tb/tb_mm_master.sv
// Self-checking bench for mm_master: directed scenarios plus random traffic scored against a memory-level model.
`timescale 1ns/1ps
module tb_mm_master;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_address;
  logic [DW-1:0] cmd_writedata;
  logic          rsp_valid, rsp_write, rsp_error;
  logic [DW-1:0] rsp_readdata;
  logic [AW-1:0] address;
  logic          read, write;
  logic [DW-1:0] writedata, readdata;
  logic          waitrequest;

  always #5 clk = ~clk;

  mm_master #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_address(cmd_address), .cmd_writedata(cmd_writedata),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_readdata(rsp_readdata),
    .rsp_error(rsp_error),
    .address(address), .read(read), .write(write), .writedata(writedata),
    .readdata(readdata), .waitrequest(waitrequest)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Slave: plain memory, initialised to mem[i] = i; readdata only meaningful while read is high.
  logic          mem_ready = 1'b0;
  logic [DW-1:0] slave_mem [256];
  assign readdata = read ? slave_mem[address] : 16'hdead;

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) slave_mem[i] <= DW'(i);
    end else if (write && !waitrequest) begin
      slave_mem[address] <= writedata;
    end
  end

  // Reference model: commands take effect in acceptance order; each yields one response.
  typedef struct {
    logic          wr;
    logic [DW-1:0] rd;
    logic          err;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] model_mem [256];
  logic [DW-1:0] last_rd;
  logic          abort_next = 1'b0;
  logic          prev_stall;
  logic [AW-1:0] prev_addr;
  logic [DW-1:0] prev_wdata;
  logic          prev_rd, prev_wr;
  int            rsp_count = 0;

  always @(negedge clk) begin
    exp_t e;
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) model_mem[i] = DW'(i);
    end
    if (!rst_n) begin
      exp_q.delete();
      last_rd    = '0;
      prev_stall = 1'b0;
    end else begin
      check("rd_wr_exclusive", {31'd0, read && write}, 32'd0);
`ifdef MM_MASTER_TIMEOUT_EN
      if (prev_stall && (read || write)) begin
`else
      if (prev_stall) begin
`endif
        check("stall_address", {24'd0, address}, {24'd0, prev_addr});
        check("stall_writedata", {16'd0, writedata}, {16'd0, prev_wdata});
        check("stall_rdwr", {30'd0, read, write}, {30'd0, prev_rd, prev_wr});
      end
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          rsp_count++;
          $display("rsp %0d: write=%0b readdata=0x%h error=%0b", rsp_count, rsp_write, rsp_readdata, rsp_error);
          check("rsp_write", {31'd0, rsp_write}, {31'd0, e.wr});
          check("rsp_readdata", {16'd0, rsp_readdata}, {16'd0, e.rd});
          check("rsp_error", {31'd0, rsp_error}, {31'd0, e.err});
        end
      end
      if (cmd_valid && cmd_ready) begin
        if (abort_next) begin
          e = '{wr: cmd_write, rd: last_rd, err: 1'b1};
        end else if (cmd_write) begin
          model_mem[cmd_address] = cmd_writedata;
          e = '{wr: 1'b1, rd: last_rd, err: 1'b0};
        end else begin
          last_rd = model_mem[cmd_address];
          e = '{wr: 1'b0, rd: last_rd, err: 1'b0};
        end
        exp_q.push_back(e);
      end
      prev_stall = (read || write) && waitrequest;
      prev_addr  = address;
      prev_wdata = writedata;
      prev_rd    = read;
      prev_wr    = write;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic v, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cmd_valid     = v;
    cmd_write     = w;
    cmd_address   = a;
    cmd_writedata = d;
  endtask

  initial begin
    int stall_run;
    rst_n = 1'b0;
    waitrequest = 1'b0;
    set_cmd(1'b0, 1'b0, '0, '0);

    // Reset held for 10 cycles.
    repeat (10) step();
    check("reset_read", {31'd0, read}, 32'd0);
    check("reset_write", {31'd0, write}, 32'd0);
    check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("reset_address", {24'd0, address}, 32'd0);
    check("reset_rsp_readdata", {16'd0, rsp_readdata}, 32'd0);
    mem_ready = 1'b1;
    rst_n = 1'b1;
    step();
    check("idle_no_bus", {30'd0, read, write}, 32'd0);
    check("idle_no_rsp", {31'd0, rsp_valid}, 32'd0);

    // Zero-wait read at address 1.
    set_cmd(1'b1, 1'b0, 8'd1, 16'h0);
    step();
    set_cmd(1'b0, 1'b0, 8'd0, 16'h0);
    check("rd0_read", {31'd0, read}, 32'd1);
    check("rd0_address", {24'd0, address}, 32'd1);
    check("rd0_no_rsp_yet", {31'd0, rsp_valid}, 32'd0);
    step();
    check("rd0_read_drop", {31'd0, read}, 32'd0);
    check("rd0_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("rd0_rsp_data", {16'd0, rsp_readdata}, 32'd1);
    step();
    check("rd0_rsp_pulse", {31'd0, rsp_valid}, 32'd0);

    // Write with 3 stall cycles; waitrequest is ignored while idle.
    waitrequest = 1'b1;
    set_cmd(1'b1, 1'b1, 8'd1, 16'h1234);
    check("idle_ignores_wait", {31'd0, cmd_ready}, 32'd1);
    step();
    set_cmd(1'b0, 1'b0, 8'd0, 16'h0);
    for (int i = 0; i < 3; i++) begin
      check("wr_stall_write", {31'd0, write}, 32'd1);
      check("wr_stall_addr", {24'd0, address}, 32'd1);
      check("wr_stall_data", {16'd0, writedata}, 32'h1234);
      check("wr_stall_ready", {31'd0, cmd_ready}, 32'd0);
      step();
    end
    waitrequest = 1'b0;
    check("wr_last_write", {31'd0, write}, 32'd1);
    step();
    check("wr_done_write", {31'd0, write}, 32'd0);
    check("wr_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("wr_rsp_write", {31'd0, rsp_write}, 32'd1);
    check("wr_rsp_data_hold", {16'd0, rsp_readdata}, 32'd1);
    step();

    // Back-to-back reads at 2, 3, 3.
    set_cmd(1'b1, 1'b0, 8'd2, 16'h0);
    step();
    check("b2b_read0", {31'd0, read}, 32'd1);
    check("b2b_addr0", {24'd0, address}, 32'd2);
    set_cmd(1'b1, 1'b0, 8'd3, 16'h0);
    step();
    check("b2b_read1", {31'd0, read}, 32'd1);
    check("b2b_addr1", {24'd0, address}, 32'd3);
    check("b2b_rsp0", {15'd0, rsp_valid, rsp_readdata}, {15'd0, 1'b1, 16'd2});
    step();
    check("b2b_read2", {31'd0, read}, 32'd1);
    check("b2b_rsp1", {15'd0, rsp_valid, rsp_readdata}, {15'd0, 1'b1, 16'd3});
    set_cmd(1'b0, 1'b0, 8'd0, 16'h0);
    step();
    check("b2b_read_end", {31'd0, read}, 32'd0);
    check("b2b_rsp2", {15'd0, rsp_valid, rsp_readdata}, {15'd0, 1'b1, 16'd3});
    step();
    check("b2b_rsp_end", {31'd0, rsp_valid}, 32'd0);

    // Reset during a stalled read.
    waitrequest = 1'b1;
    set_cmd(1'b1, 1'b0, 8'd4, 16'h0);
    step();
    set_cmd(1'b0, 1'b0, 8'd0, 16'h0);
    step();
    check("mid_rst_read_before", {31'd0, read}, 32'd1);
    #2 rst_n = 1'b0;
    #1 check("mid_rst_read_async", {31'd0, read}, 32'd0);
    repeat (3) step();
    rst_n = 1'b1;
    waitrequest = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("mid_rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end

`ifdef MM_MASTER_TIMEOUT_EN
    // Read with waitrequest stuck high aborts after TO stall cycles.
    waitrequest = 1'b1;
    abort_next  = 1'b1;
    set_cmd(1'b1, 1'b0, 8'd5, 16'h0);
    step();
    abort_next = 1'b0;
    set_cmd(1'b0, 1'b0, 8'd0, 16'h0);
    for (int i = 0; i < TO; i++) begin
      check("to_read_held", {31'd0, read}, 32'd1);
      step();
    end
    check("to_read_drop", {31'd0, read}, 32'd0);
    check("to_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("to_rsp_error", {31'd0, rsp_error}, 32'd1);
    check("to_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    waitrequest = 1'b0;
    set_cmd(1'b1, 1'b0, 8'd6, 16'h0);
    step();
    set_cmd(1'b0, 1'b0, 8'd0, 16'h0);
    check("to_next_read", {31'd0, read}, 32'd1);
    step();
    check("to_next_rsp", {15'd0, rsp_valid, rsp_readdata}, {15'd0, 1'b1, 16'd6});
    step();
`endif

    // Random traffic: stalls capped below the timeout limit.
    stall_run = 0;
    for (int n = 0; n < 300; n++) begin
      set_cmd(($urandom_range(0, 9) < 7), $urandom_range(0, 1) == 1,
              AW'($urandom_range(0, 15)), DW'($urandom));
      if (stall_run >= 3 || $urandom_range(0, 9) >= 3) begin
        waitrequest = 1'b0;
        stall_run   = 0;
      end else begin
        waitrequest = 1'b1;
        stall_run++;
      end
      step();
    end
    set_cmd(1'b0, 1'b0, 8'd0, 16'h0);
    waitrequest = 1'b0;
    repeat (5) step();
    check("drain_empty", exp_q.size(), 32'd0);
    check("drain_idle", {30'd0, read, write}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mm_master.md
# mm_master

Avalon-MM initiator that turns a simple command stream (valid/ready) into single read/write transfers on a waitrequest-flow-controlled memory-mapped port and returns one response per command. It is the master-side counterpart of the team's `mm` slave. It sits between control logic (sequencers, register scripts) and any `mm`-style slave. Back-to-back transfers run at one per cycle when the slave does not stall.

## Interface
- `AW`, 8: address width.
- `DW`, 16: data width.
- `TIMEOUT`, 255: stall-cycle limit. Used only with `MM_MASTER_TIMEOUT_EN`. Must be ≥1.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted on the edge where `cmd_valid && cmd_ready`.
- `cmd_write`  in  1  1 = write, 0 = read.
- `cmd_address`  in  AW  transfer address.
- `cmd_writedata`  in  DW  write data; ignored for reads.
- `rsp_valid`  out  1  one-cycle pulse per completed or aborted command; no backpressure.
- `rsp_write`  out  1  response belongs to a write.
- `rsp_readdata`  out  DW  captured `readdata` of the last completed read.
- `rsp_error`  out  1  transfer aborted by timeout.
- `address`  out  AW  Avalon-MM address.
- `read`  out  1  Avalon-MM read.
- `write`  out  1  Avalon-MM write.
- `writedata`  out  DW  Avalon-MM write data.
- `readdata`  in  DW  Avalon-MM read data; valid in the completion cycle.
- `waitrequest`  in  1  slave stall.

## Operation
- FSM states: IDLE and BUSY. Reset state is IDLE.
- `cmd_ready` = (IDLE) || (BUSY && !`waitrequest`). This is combinational from `waitrequest`.
- **IDLE, command accepted:** register `address`, `writedata`, `read` = !`cmd_write` and `write` = `cmd_write`. Go to BUSY.
- **BUSY:** a transfer completes in any cycle where `waitrequest` = 0.
  - While `waitrequest` = 1, `address`, `read`, `write` and `writedata` stay stable.
  - On completion with `cmd_valid` = 1, load the next command and stay in BUSY. This gives back-to-back transfers.
  - On completion with `cmd_valid` = 0, clear `read` and `write` and go to IDLE.
- `read` and `write` are never high together. Both are 0 in IDLE.
- Response on completion, registered one cycle later:
  - `rsp_valid` = 1 for one cycle and `rsp_write` = type of the completed transfer.
  - For a read, `rsp_readdata` takes the `readdata` sampled in the completion cycle.
  - `rsp_readdata` holds its value across writes.
  - `rsp_error` = 0.
- Reset values: `cmd_ready` = 1 (IDLE). `read`, `write`, `rsp_valid`, `rsp_write` and `rsp_error` are 0. `address`, `writedata` and `rsp_readdata` are 0.
- Reset asserted mid-transfer: `read`/`write` drop asynchronously. The in-flight command is discarded with no response.

## Timing
- Command accepted at edge N: `read`/`write` are high during cycle N+1.
- Zero-wait slave: the transfer completes at edge N+1 and `rsp_valid` is high in cycle N+2. Minimum latency from command to response is 2 cycles.
- Each cycle with `waitrequest` = 1 adds one cycle of latency.
- Throughput with a zero-wait slave and continuous `cmd_valid`: one transfer per cycle, with `rsp_valid` high every cycle.
- `waitrequest` is sampled only while `read` or `write` is high. It is ignored in IDLE.

## Configuration
- `MM_MASTER_TIMEOUT_EN` defined: a stall counter runs.
  - It resets to 0 on each new transfer and increments each BUSY cycle with `waitrequest` = 1.
  - When it reaches `TIMEOUT`, the transfer is aborted: `read`/`write` go to 0 and the FSM goes to IDLE. `cmd_ready` stays 0 in that abort cycle.
  - The next cycle gives `rsp_valid` = 1 and `rsp_error` = 1, with `rsp_readdata` unchanged.
- `MM_MASTER_TIMEOUT_EN` undefined: no counter, `rsp_error` is tied to 0, and the block waits indefinitely on `waitrequest`.

## Test plan
- Reset: hold `rst_n` = 0 for 10 cycles. Check `read` = `write` = `rsp_valid` = 0 and `cmd_ready` = 1. After release, an idle cycle produces no bus activity.
- Read with zero wait: command read at address 1; slave model returns `readdata` = `address`. Expect `read` high for one cycle with `address` = 1, then `rsp_valid` = 1 next cycle with `rsp_readdata` = 1 and `rsp_write` = 0.
- Write with stall: command write at address 1 with data 0x1234; slave holds `waitrequest` = 1 for 3 cycles. Expect `write`, `address` and `writedata` stable for 4 cycles, then `rsp_valid` = 1 with `rsp_write` = 1. `rsp_readdata` is unchanged (1).
- Back-to-back reads: `cmd_valid` held for reads at addresses 2, 3, 3 with a zero-wait slave. Expect `read` high for 3 consecutive cycles and 3 consecutive `rsp_valid` pulses with `rsp_readdata` = 2, 3, 3.
- Mid-transfer reset: assert `rst_n` = 0 during a stalled read. `read` drops immediately and no `rsp_valid` appears after release.
- With `MM_MASTER_TIMEOUT_EN` and `TIMEOUT` = 8: read with `waitrequest` stuck at 1. Expect `read` to drop after 8 stall cycles, then `rsp_valid` = 1 and `rsp_error` = 1, and the next command to be accepted normally.
